ram_responder: RTL and testbench

Memory-side responder for the single-word RAM request interface driven by the cache management unit. It accepts one read or write request at a time, holds it for a fixed number of wait cycles to model main-memory latency, performs the access on an internal word array, and signals completion with an acknowledge. It sits between the cache controller's `ram_*` port group and the backing storage, and replaces the behavioural RAM in simulation and on the board.

---
 rtl/mem_if_pkg.sv | 20 ++
 rtl/ram_responder_if.sv | 33 +++
 rtl/ram_responder_ram_array.sv | 39 +++
 rtl/ram_responder.sv | 118 +++++++++++
 tb/tb_ram_responder.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_if_pkg.sv
// -----------------------------------------------------------------------------
// mem_if_pkg
// Definitions shared by the cache controller's RAM port group and the
// memory-side responder: the responder state encoding and line geometry.
// No ports.
// -----------------------------------------------------------------------------
package mem_if_pkg;

   typedef enum logic {
      RSP_IDLE,
      RSP_WAIT
   } rsp_state_t;

   // Byte-address bits below the word index.
   localparam int unsigned WORD_OFFSET = 2;

   // Words per cache line; the controller issues this many single-word requests.
   localparam int unsigned BLOCK_WORDS = 4;

endpackage

// File: rtl/ram_responder_if.sv
// -----------------------------------------------------------------------------
// ram_responder_if
// Single-word RAM request port group between the cache controller (master)
// and the memory responder (slave).
//   cs    request strobe          (master -> slave)
//   we    1 = write, 0 = read     (master -> slave)
//   addr  byte address            (master -> slave)
//   din   write data              (master -> slave)
//   dout  data of last read       (slave -> master)
//   ack   idle / request done     (slave -> master)
//   stall request in flight       (slave -> master)
// -----------------------------------------------------------------------------
interface ram_responder_if;

   logic        cs;
   logic        we;
   logic [31:0] addr;
   logic [31:0] din;
   logic [31:0] dout;
   logic        ack;
   logic        stall;

   modport master (
      output cs, we, addr, din,
      input  dout, ack, stall
   );

   modport slave (
      input  cs, we, addr, din,
      output dout, ack, stall
   );

endinterface

// File: rtl/ram_responder_ram_array.sv
// -----------------------------------------------------------------------------
// ram_array
// Single-port synchronous 32-bit word array with a registered read port, so
// it maps onto block RAM. Contents are not reset.
//   clk    clock
//   en     access enable (one access per enabled cycle)
//   we     1 = write wdata to waddr, 0 = read waddr into rdata
//   waddr  word address (ADDR_WIDTH bits)
//   wdata  write data
//   rdata  read data, updated only by an enabled read
// -----------------------------------------------------------------------------
module ram_array #(
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [31:0] mem [DEPTH];

   // rdata holds across writes and idle cycles so the responder's dout only
   // moves when a read completes.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[waddr] <= wdata;
         end else begin
            rdata <= mem[waddr];
         end
      end
   end

endmodule

// File: rtl/ram_responder.sv
// -----------------------------------------------------------------------------
// ram_responder
// Memory-side responder for the cache controller's single-word RAM port.
// Accepts one read or write at a time, holds it for LATENCY cycles to model
// main-memory latency, then performs the access on an internal word array.
//   clk   system clock, all state changes on the rising edge
//   rst   asynchronous active-low reset
//   bus   ram_responder_if.slave : cs, we, addr, din in; dout, ack, stall out
// Parameters:
//   ADDR_WIDTH  word-address bits (depth = 2**ADDR_WIDTH words)
//   LATENCY     cycles from acceptance to completion, 1..15
// -----------------------------------------------------------------------------
module ram_responder
   import mem_if_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned LATENCY    = 3
) (
   input  logic            clk,
   input  logic            rst,
   ram_responder_if.slave  bus
);

   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   rsp_state_t            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  req_we_q;
   logic [ADDR_WIDTH-1:0] req_word_q;
   logic [31:0]           req_din_q;
   logic                  rd_valid_q, rd_valid_d;
   logic                  capture;
   logic                  complete;
   logic [31:0]           rdata;

   // Byte offset and bits above the array depth are don't-care: aliasing.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.addr[31:ADDR_WIDTH+WORD_OFFSET],
                               bus.addr[WORD_OFFSET-1:0]};

   // Next-state logic. On the completion cycle a new strobe is taken at the
   // same edge, so back-to-back requests run one word per LATENCY cycles;
   // a strobe earlier in WAIT is dropped.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      capture  = 1'b0;
      complete = 1'b0;
      unique case (state_q)
         RSP_IDLE: begin
            if (bus.cs) begin
               capture = 1'b1;
               cnt_d   = CNT_LOAD;
               state_d = RSP_WAIT;
            end
         end
         RSP_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               complete = 1'b1;
               if (bus.cs) begin
                  capture = 1'b1;
                  cnt_d   = CNT_LOAD;
               end else begin
                  state_d = RSP_IDLE;
               end
            end
         end
         default: begin
            state_d = RSP_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign rd_valid_d = rd_valid_q | (complete & ~req_we_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= RSP_IDLE;
         cnt_q      <= '0;
         req_we_q   <= 1'b0;
         req_word_q <= '0;
         req_din_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_valid_q <= rd_valid_d;
         if (capture) begin
            req_we_q   <= bus.we;
            req_word_q <= bus.addr[ADDR_WIDTH+WORD_OFFSET-1:WORD_OFFSET];
            req_din_q  <= bus.din;
         end
      end
   end

   // The array is only touched on the completion cycle, so a reset during
   // WAIT drops the request without writing.
   ram_array #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram_array (
      .clk   (clk),
      .en    (complete),
      .we    (req_we_q),
      .waddr (req_word_q),
      .wdata (req_din_q),
      .rdata (rdata)
   );

   // The block-RAM output register carries no reset; rd_valid_q masks it so
   // dout reads 0 from reset until the first completed read.
   assign bus.dout  = rd_valid_q ? rdata : '0;
   assign bus.ack   = (state_q == RSP_IDLE);
   assign bus.stall = (state_q != RSP_IDLE);

endmodule

// File: tb/tb_ram_responder.sv
module tb_ram_responder;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   ram_responder_if bus ();

   ram_responder #(
      .ADDR_WIDTH (10),
      .LATENCY    (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- drive helpers ----------------
   task automatic wait_ack();
      int n;
      n = 0;
      while (bus.ack !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (bus.ack !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL wait_ack: ack=%b after %0d cycles, required 1", bus.ack, n);
      end
   endtask

   // Returns #1 after the accepting edge.
   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
      wait_ack();
      bus.cs   = 1'b1;
      bus.we   = w;
      bus.addr = a;
      bus.din  = d;
      @(posedge clk); #1;
      bus.cs   = 1'b0;
      bus.we   = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] data);
      issue(1'b0, a, 32'h0);
      wait_ack();
      data = bus.dout;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL reset_ack: got %b need 1", bus.ack); end
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b need 0", bus.stall); end
      checks++; if (bus.dout !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h need 0", bus.dout); end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL post_reset_ack: got %b need 1", bus.ack); end
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL post_reset_stall: got %b need 0", bus.stall); end
      checks++; if (bus.dout !== 32'h0) begin errors++; $display("FAIL post_reset_dout: got %h need 0", bus.dout); end
   endtask

   task automatic test_write_read();
      wait_ack();
      bus.cs = 1'b1; bus.we = 1'b1; bus.addr = 32'h10; bus.din = 32'hDEADBEEF;
      @(posedge clk); #1;  // edge 0: write accepted
      bus.cs = 1'b0;
      checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL wr_ack_e0: got %b need 0", bus.ack); end
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL wr_stall_e0: got %b need 1", bus.stall); end
      @(posedge clk); #1;  // edge 1
      checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL wr_ack_e1: got %b need 0", bus.ack); end
      @(posedge clk); #1;  // edge 2
      checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL wr_ack_e2: got %b need 0", bus.ack); end
      bus.cs = 1'b1; bus.we = 1'b0; bus.addr = 32'h10;
      @(posedge clk); #1;  // edge 3: write completes, read accepted
      bus.cs = 1'b0;
      checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL rd_ack_e3: got %b need 0", bus.ack); end
      checks++; if (bus.dout !== 32'h0) begin errors++; $display("FAIL rd_dout_e3: got %h need 0", bus.dout); end
      @(posedge clk); #1;  // edge 4
      checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL rd_ack_e4: got %b need 0", bus.ack); end
      @(posedge clk); #1;  // edge 5
      checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL rd_ack_e5: got %b need 0", bus.ack); end
      checks++; if (bus.dout !== 32'h0) begin errors++; $display("FAIL rd_dout_e5: got %h need 0", bus.dout); end
      @(posedge clk); #1;  // edge 6: read completes
      checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL rd_ack_e6: got %b need 1", bus.ack); end
      checks++; if (bus.dout !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_dout_e6: got %h need deadbeef", bus.dout); end
   endtask

   task automatic test_ack_timing();
      int low;
      issue(1'b1, 32'h100, 32'h1);
      low = 0;
      while (bus.ack === 1'b0 && low < 20) begin
         low++;
         @(posedge clk); #1;
      end
      checks++; if (low != 3) begin errors++; $display("FAIL ack_low_cycles: got %0d need 3", low); end
   endtask

   task automatic test_line_fill();
      logic [31:0] exp [4];
      exp[0] = 32'h11; exp[1] = 32'h22; exp[2] = 32'h33; exp[3] = 32'h44;
      for (int i = 0; i < 4; i++) issue(1'b1, 32'h40 + 32'(4 * i), exp[i]);
      wait_ack();
      bus.cs = 1'b1; bus.we = 1'b0; bus.addr = 32'h40;
      @(posedge clk); #1;  // read 0 accepted
      bus.addr = 32'h44;
      for (int i = 0; i < 4; i++) begin
         repeat (2) begin @(posedge clk); #1; end
         checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL fill_busy[%0d]: ack=%b need 0", i, bus.ack); end
         if (i == 3) bus.cs = 1'b0;
         @(posedge clk); #1;  // completion of read i
         checks++; if (bus.dout !== exp[i]) begin errors++; $display("FAIL fill_data[%0d]: got %h need %h", i, bus.dout, exp[i]); end
         if (i < 2) bus.addr = 32'h40 + 32'(4 * (i + 2));
      end
      checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL fill_done_ack: got %b need 1", bus.ack); end
   endtask

   task automatic test_cs_busy();
      logic [31:0] d;
      issue(1'b1, 32'h80, 32'h0);
      issue(1'b1, 32'h84, 32'h99);
      bus.cs = 1'b1; bus.we = 1'b1; bus.addr = 32'h80; bus.din = 32'h55;
      @(posedge clk); #1;  // mid-WAIT strobe, must be dropped
      bus.cs = 1'b0; bus.we = 1'b0;
      checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL busy_ack: got %b need 0", bus.ack); end
      do_read(32'h80, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL busy_ignored: got %h need 0", d); end
      do_read(32'h84, d);
      checks++; if (d !== 32'h99) begin errors++; $display("FAIL busy_req_kept: got %h need 99", d); end
   endtask

   task automatic test_alias();
      logic [31:0] d;
      issue(1'b1, 32'h1003, 32'hA5A5A5A5);
      do_read(32'h0, d);
      checks++; if (d !== 32'hA5A5A5A5) begin errors++; $display("FAIL alias_0: got %h need a5a5a5a5", d); end
      do_read(32'h0000_1002, d);
      checks++; if (d !== 32'hA5A5A5A5) begin errors++; $display("FAIL alias_1002: got %h need a5a5a5a5", d); end
   endtask

   task automatic test_async_reset();
      issue(1'b0, 32'h0, 32'h0);
      #3;
      checks++; if (bus.dout !== 32'hA5A5A5A5) begin errors++; $display("FAIL pre_areset_dout: got %h need a5a5a5a5", bus.dout); end
      rst = 1'b0;
      #1;
      checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL areset_ack: got %b need 1", bus.ack); end
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL areset_stall: got %b need 0", bus.stall); end
      checks++; if (bus.dout !== 32'h0) begin errors++; $display("FAIL areset_dout: got %h need 0", bus.dout); end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_wait();
      logic [31:0] d;
      issue(1'b1, 32'h20, 32'h0);
      issue(1'b1, 32'h20, 32'h77);
      @(posedge clk); #1;  // one cycle into WAIT
      rst = 1'b0;
      #1;
      checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL wreset_ack: got %b need 1", bus.ack); end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL wreset_idle: got %b need 1", bus.ack); end
      do_read(32'h20, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL wreset_dropped: got %h need 0", d); end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      bus.cs   = 1'b0;
      bus.we   = 1'b0;
      bus.addr = '0;
      bus.din  = '0;
      test_reset();
      test_write_read();
      test_ack_timing();
      test_line_fill();
      test_cs_busy();
      test_alias();
      test_async_reset();
      test_reset_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
